// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and default constants for the clock-gating enable controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_e;

    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_WAKE_CYCLES = 2;
    localparam int unsigned DEF_EVT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: count updates one edge after inc_i/clr_i. No backpressure.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Drives the enable of a clock-gating cell: gates after an idle period, reopens on wake.
// Latency: gating after thr_eff idle edges; ack WAKE_CYCLES edges after reopening. No backpressure.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int unsigned EVT_W       = DEF_EVT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_auto_i,
    input  logic [CNT_W-1:0] idle_thr_i,
    input  logic             busy_i,
    input  logic             force_on_i,
    input  logic             wake_req_i,
    output logic             wake_ack_o,
    output logic             clk_en_o,
    input  logic             scan_mode_i,
    output logic             scan_cg_en_o,
    output logic             gated_o,
    input  logic             clr_evt_i,
    output logic [EVT_W-1:0] evt_cnt_o
);

    if (WAKE_CYCLES >= (64'd1 << CNT_W)) begin : g_wake_range
        $error("WAKE_CYCLES must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] WAKE_LAST =
        (WAKE_CYCLES == 0) ? '0 : CNT_W'(WAKE_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_en_q;
    logic             ack_q;
    logic             gated_q;

    logic             abort;
    logic [CNT_W-1:0] thr_last;
    logic             gate_now;

    assign abort    = busy_i | wake_req_i | force_on_i | ~enable_auto_i;
    // A threshold of 0 behaves as 1, so the last idle count is 0 in both cases.
    assign thr_last = (idle_thr_i == '0) ? '0 : idle_thr_i - 1'b1;
    assign gate_now = (state_q == IDLE) && !abort && (cnt_q >= thr_last);

    // Outputs are flops updated with the state, so the cell enable never glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            ack_q    <= 1'b1;
            gated_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!abort) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                IDLE: begin
                    if (abort) begin
                        state_q <= RUN;
                    end else if (gate_now) begin
                        state_q  <= GATED;
                        clk_en_q <= 1'b0;
                        ack_q    <= 1'b0;
                        gated_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GATED: begin
                    if (abort) begin
                        cnt_q    <= '0;
                        clk_en_q <= 1'b1;
                        gated_q  <= 1'b0;
                        if (WAKE_CYCLES == 0) begin
                            state_q <= RUN;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= WAKE;
                        end
                    end
                end
                WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_q <= RUN;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    clk_en_q <= 1'b1;
                    ack_q    <= 1'b1;
                    gated_q  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (EVT_W)
    ) u_evt_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (gate_now),
        .clr_i   (clr_evt_i),
        .count_o (evt_cnt_o)
    );

    assign clk_en_o     = clk_en_q;
    assign wake_ack_o   = ack_q;
    assign gated_o      = gated_q;
    assign scan_cg_en_o = scan_mode_i;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: a default instance plus a WAKE_CYCLES=0, 4-bit event counter instance.
module tb_clk_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_auto = 1'b1;
    logic [7:0] idle_thr = 8'd4;
    logic       busy = 1'b0;
    logic       force_on = 1'b0;
    logic       wake_req = 1'b0;
    logic       scan_mode = 1'b0;
    logic       clr_evt = 1'b0;

    logic        wake_ack, clk_en, scan_cg_en, gated;
    logic [15:0] evt;
    logic        wake_ack_z, clk_en_z, scan_cg_en_z, gated_z;
    logic [3:0]  evt_z;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    clk_gate_ctrl dut (
        .clk_i(clk), .rst_i(rst), .enable_auto_i(enable_auto), .idle_thr_i(idle_thr),
        .busy_i(busy), .force_on_i(force_on), .wake_req_i(wake_req), .wake_ack_o(wake_ack),
        .clk_en_o(clk_en), .scan_mode_i(scan_mode), .scan_cg_en_o(scan_cg_en),
        .gated_o(gated), .clr_evt_i(clr_evt), .evt_cnt_o(evt)
    );

    clk_gate_ctrl #(.CNT_W(8), .WAKE_CYCLES(0), .EVT_W(4)) dut_z (
        .clk_i(clk), .rst_i(rst), .enable_auto_i(enable_auto), .idle_thr_i(idle_thr),
        .busy_i(busy), .force_on_i(force_on), .wake_req_i(wake_req), .wake_ack_o(wake_ack_z),
        .clk_en_o(clk_en_z), .scan_mode_i(scan_mode), .scan_cg_en_o(scan_cg_en_z),
        .gated_o(gated_z), .clr_evt_i(clr_evt), .evt_cnt_o(evt_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Counts edges until the chosen instance drops clk_en; -1 when the bound expires.
    task automatic wait_fall(input bit zero, input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((zero ? clk_en_z : clk_en) !== 1'b0) && (n < bound));
        if ((zero ? clk_en_z : clk_en) !== 1'b0) n = -1;
    endtask

    task automatic test_reset();
        int n, e;
        rst = 1'b1; busy = 1'b0; enable_auto = 1'b1; idle_thr = 8'd4;
        tick();
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL rst_clk_en got=%b exp=1", clk_en); end
        checks++; if (wake_ack !== 1'b1) begin errors++; $display("FAIL rst_ack got=%b exp=1", wake_ack); end
        checks++; if (gated !== 1'b0) begin errors++; $display("FAIL rst_gated got=%b exp=0", gated); end
        checks++; if (evt !== 16'd0) begin errors++; $display("FAIL rst_evt got=%0d exp=0", evt); end
        tick();
        rst = 1'b0;
        exp_q.push_back(5);
        wait_fall(1'b0, 50, n);
        e = exp_q.pop_front();
        checks++; if (n !== e) begin errors++; $display("FAIL idle_latency got=%0d exp=%0d", n, e); end
        checks++; if (gated !== 1'b1) begin errors++; $display("FAIL idle_gated got=%b exp=1", gated); end
        checks++; if (wake_ack !== 1'b0) begin errors++; $display("FAIL idle_ack got=%b exp=0", wake_ack); end
        checks++; if (evt !== 16'd1) begin errors++; $display("FAIL idle_evt got=%0d exp=1", evt); end
    endtask

    task automatic test_abort_at_threshold();
        int n, e;
        idle_thr = 8'd4;
        do_reset();
        repeat (4) tick();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL abort_clk_en got=%b exp=1", clk_en); end
        checks++; if (evt !== 16'd0) begin errors++; $display("FAIL abort_evt got=%0d exp=0", evt); end
        exp_q.push_back(5);
        wait_fall(1'b0, 50, n);
        e = exp_q.pop_front();
        checks++; if (n !== e) begin errors++; $display("FAIL abort_regate got=%0d exp=%0d", n, e); end
    endtask

    task automatic test_wake();
        int n, e;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        wake_req = 1'b1;
        tick();
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL wake_clk_en got=%b exp=1", clk_en); end
        checks++; if (clk_en_z !== 1'b1 || wake_ack_z !== 1'b1) begin
            errors++; $display("FAIL wake0_ack got=%b%b exp=11", clk_en_z, wake_ack_z); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++; if (wake_ack !== e[0]) begin errors++; $display("FAIL wake_ack[%0d] got=%b exp=%0d", i, wake_ack, e); end
            if (i < 2) tick();
        end
        wake_req = 1'b0;
        exp_q.push_back(5);
        wait_fall(1'b0, 50, n);
        e = exp_q.pop_front();
        checks++; if (n !== e) begin errors++; $display("FAIL wake_regate got=%0d exp=%0d", n, e); end
        // One-cycle request: the wake sequence must still complete.
        wake_req = 1'b1;
        tick();
        wake_req = 1'b0;
        tick();
        checks++; if (clk_en !== 1'b1 || wake_ack !== 1'b0) begin
            errors++; $display("FAIL wake_pulse_mid got=%b%b exp=10", clk_en, wake_ack); end
        tick();
        checks++; if (wake_ack !== 1'b1) begin errors++; $display("FAIL wake_pulse_ack got=%b exp=1", wake_ack); end
    endtask

    task automatic test_thresholds();
        int n, e;
        idle_thr = 8'd0;
        do_reset();
        exp_q.push_back(2);
        wait_fall(1'b0, 50, n);
        e = exp_q.pop_front();
        checks++; if (n !== e) begin errors++; $display("FAIL thr0 got=%0d exp=%0d", n, e); end
        idle_thr = 8'd255;
        do_reset();
        exp_q.push_back(256);
        wait_fall(1'b0, 300, n);
        e = exp_q.pop_front();
        checks++; if (n !== e) begin errors++; $display("FAIL thr255 got=%0d exp=%0d", n, e); end
        idle_thr = 8'd200;
        do_reset();
        repeat (51) tick();
        checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL thr_lower_early got=%b exp=1", clk_en); end
        idle_thr = 8'd10;
        tick();
        checks++; if (clk_en !== 1'b0 || gated !== 1'b1) begin
            errors++; $display("FAIL thr_lower got=%b%b exp=01", clk_en, gated); end
    endtask

    task automatic test_overrides();
        int n, e, lows;
        idle_thr = 8'd4;
        force_on = 1'b1;
        do_reset();
        lows = 0;
        for (int i = 0; i < 300; i++) begin tick(); if (clk_en !== 1'b1) lows++; end
        checks++; if (lows !== 0) begin errors++; $display("FAIL force_on lows=%0d exp=0", lows); end
        force_on = 1'b0;
        enable_auto = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin tick(); if (clk_en !== 1'b1) lows++; end
        checks++; if (lows !== 0) begin errors++; $display("FAIL auto_off lows=%0d exp=0", lows); end
        enable_auto = 1'b1;
        exp_q.push_back(5);
        wait_fall(1'b0, 50, n);
        e = exp_q.pop_front();
        checks++; if (n !== e) begin errors++; $display("FAIL auto_on got=%0d exp=%0d", n, e); end
        for (int i = 0; i < 4; i++) begin
            scan_mode = i[0];
            #1;
            checks++; if (scan_cg_en !== scan_mode || scan_cg_en_z !== scan_mode) begin
                errors++; $display("FAIL scan[%0d] got=%b exp=%b", i, scan_cg_en, scan_mode); end
            tick();
        end
        scan_mode = 1'b0;
        checks++; if (gated !== 1'b1) begin errors++; $display("FAIL scan_state got=%b exp=1", gated); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (clk_en !== 1'b1 || gated !== 1'b0 || wake_ack !== 1'b1) begin
            errors++; $display("FAIL rst_in_gated got=%b%b%b exp=101", clk_en, gated, wake_ack); end
    endtask

    task automatic test_counter();
        int n, e;
        idle_thr = 8'd0;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            exp_q.push_back((i > 15) ? 15 : i);
            wait_fall(1'b1, 20, n);
            e = exp_q.pop_front();
            checks++; if (n < 0 || evt_z !== 4'(e)) begin
                errors++; $display("FAIL evt_sat[%0d] got=%0d exp=%0d edges=%0d", i, evt_z, e, n); end
            busy = 1'b1; tick(); busy = 1'b0;
        end
        tick();
        clr_evt = 1'b1;
        tick();
        clr_evt = 1'b0;
        checks++; if (clk_en_z !== 1'b0 || evt_z !== 4'd0) begin
            errors++; $display("FAIL clr_vs_inc got=%b/%0d exp=0/0", clk_en_z, evt_z); end
        busy = 1'b1; tick(); busy = 1'b0;
        wait_fall(1'b1, 20, n);
        checks++; if (n < 0 || evt_z !== 4'd1) begin
            errors++; $display("FAIL evt_after_clr got=%0d exp=1 edges=%0d", evt_z, n); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abort_at_threshold();
        test_wake();
        test_thresholds();
        test_overrides();
        test_counter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
